// File: rtl/booth_r4_seq_mult_p.sv
// Sequential radix-4 Booth multiplier.
// One Booth digit of the (WIDTH+2)-bit extended multiplier is retired per clock
// into a 2*WIDTH+4 bit two's-complement accumulator. The multiplicand is kept
// pre-shifted by 2j and the multiplier window is shifted down by two bits per
// digit, so no variable part-selects are needed. Zero digits hold the
// accumulator (write enable low) so it does not toggle. With EARLY_TERM=1 the
// run stops as soon as every remaining Booth digit is known to be zero.
module booth_r4_seq_mult_p #(
    parameter int WIDTH      = 16,
    parameter int EARLY_TERM = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              signed_mode,
    input  logic [WIDTH-1:0]                  md,
    input  logic [WIDTH-1:0]                  mr,
    output logic                              busy,
    output logic                              done,
    output logic [2*WIDTH-1:0]                product,
    output logic [$clog2(WIDTH/2+2)-1:0]      cycles
);

    localparam int NDIG = WIDTH / 2 + 1;        // digits of the extended multiplier
    localparam int CW   = $clog2(WIDTH / 2 + 2); // width of digit index / cycle count
    localparam int AW   = 2 * WIDTH + 4;        // accumulator width
    localparam int MW   = WIDTH + 3;            // extended multiplier plus window LSB

    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [AW-1:0]    md_sh_q, md_sh_d;
    logic        [MW-1:0]    mr_sh_q, mr_sh_d;
    logic        [CW-1:0]    j_q, j_d;
    logic [2*WIDTH-1:0]      product_q, product_d;
    logic        [CW-1:0]    cycles_q, cycles_d;

    logic signed [2:0]       digit;
    logic signed [AW-1:0]    addend;
    logic signed [AW-1:0]    acc_next;
    logic                    acc_we;
    logic                    last_dig;
    logic                    capture;
    logic                    ext_md;
    logic                    ext_mr;

    // Radix-4 Booth recoding of the window {b(2j+1), b(2j), b(2j-1)} to a digit in -2..+2.
    function automatic logic signed [2:0] booth_digit(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: booth_digit = 3'sb001;
            3'b011:         booth_digit = 3'sb010;
            3'b100:         booth_digit = 3'sb110;
            3'b101, 3'b110: booth_digit = 3'sb111;
            default:        booth_digit = 3'sb000;
        endcase
    endfunction

    // Partial product digit*m at full accumulator width; negation is ~x+1.
    function automatic logic signed [AW-1:0] booth_addend(input logic signed [2:0]    dig,
                                                          input logic signed [AW-1:0] m);
        logic signed [AW-1:0] m2;
        m2 = m <<< 1;
        case (dig)
            3'sb001: booth_addend = m;
            3'sb010: booth_addend = m2;
            3'sb111: booth_addend = ~m + AW'(1);
            3'sb110: booth_addend = ~m2 + AW'(1);
            default: booth_addend = '0;
        endcase
    endfunction

    // True when all multiplier bits from the current window MSB upwards agree,
    // i.e. every digit still to come would recode to zero.
    function automatic logic rest_uniform(input logic [MW-3:0] upper);
        rest_uniform = (upper == '0) || (upper == '1);
    endfunction

    assign ext_md = signed_mode & md[WIDTH-1];
    assign ext_mr = signed_mode & mr[WIDTH-1];

    // Next-state, datapath update and operand capture.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        md_sh_d   = md_sh_q;
        mr_sh_d   = mr_sh_q;
        j_d       = j_q;
        product_d = product_q;
        cycles_d  = cycles_q;
        capture   = 1'b0;
        acc_we    = 1'b0;
        last_dig  = 1'b0;

        digit    = booth_digit(mr_sh_q[2:0]);
        addend   = booth_addend(digit, md_sh_q);
        acc_next = acc_q + addend;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                end
            end
            S_RUN: begin
                acc_we = (digit != 3'sb000);
                if (acc_we) begin
                    acc_d = acc_next;
                end
                md_sh_d = md_sh_q <<< 2;
                mr_sh_d = {{2{mr_sh_q[MW-1]}}, mr_sh_q[MW-1:2]};
                j_d     = j_q + CW'(1);
                last_dig = (j_q == LAST_DIG) ||
                           ((EARLY_TERM != 0) && rest_uniform(mr_sh_q[MW-1:2]));
                if (last_dig) begin
                    product_d = acc_next[2*WIDTH-1:0];
                    cycles_d  = j_q + CW'(1);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    capture = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            md_sh_d = {{(AW-WIDTH){ext_md}}, md};
            mr_sh_d = {{2{ext_mr}}, mr, 1'b0};
            acc_d   = '0;
            j_d     = '0;
            state_d = S_RUN;
        end
    end

    // Control, accumulator and result registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            j_q       <= '0;
            product_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            j_q       <= j_d;
            product_q <= product_d;
            cycles_q  <= cycles_d;
        end
    end

    // Operand shift registers; only meaningful while running, so no reset.
    always_ff @(posedge clk) begin
        md_sh_q <= md_sh_d;
        mr_sh_q <= mr_sh_d;
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_booth_r4_seq_mult_p.sv
// Testbench for booth_r4_seq_mult_p (WIDTH=16): one fixed-latency and one
// early-terminating instance, table vectors, random operands against a plain
// arithmetic model, and hand-written handshake/reset sequences.
module tb_booth_r4_seq_mult_p;

    localparam int W    = 16;
    localparam int NDIG = W / 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start0, start1;
    logic          sm;
    logic [W-1:0]  md, mr;
    logic          busy0, done0, busy1, done1;
    logic [2*W-1:0] prod0, prod1;
    logic [3:0]    cyc0, cyc1;

    int checks = 0;
    int errors = 0;

    booth_r4_seq_mult_p #(.WIDTH(W), .EARLY_TERM(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .signed_mode(sm),
        .md(md), .mr(mr), .busy(busy0), .done(done0),
        .product(prod0), .cycles(cyc0)
    );

    booth_r4_seq_mult_p #(.WIDTH(W), .EARLY_TERM(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm),
        .md(md), .mr(mr), .busy(busy1), .done(done1),
        .product(prod1), .cycles(cyc1)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        int             et;
        logic [2*W-1:0] p;
        int             c;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact product from ordinary integer multiplication.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        longint pa, pb, r;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        r  = pa * pb;
        return r[2*W-1:0];
    endfunction

    // Digits needed: first k such that all multiplier bits from 2k-1 upward agree.
    function automatic int ref_cycles(input logic [W-1:0] b, input logic s, input int et);
        longint v;
        if (et == 0) return NDIG;
        v = s ? longint'($signed(b)) : longint'(b);
        for (int k = 1; k < NDIG; k++) begin
            if ((v >>> (2 * k - 1)) == 0 || (v >>> (2 * k - 1)) == -1) return k;
        end
        return NDIG;
    endfunction

    task automatic wait_done(input int et, inout int lat);
        while (((et != 0) ? done1 : done0) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done (et=%0d)", et);
        end
    endtask

    task automatic do_op(input int et, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic [2*W-1:0] p, output int c, output int lat);
        @(negedge clk);
        md = a; mr = b; sm = s;
        if (et != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        lat = 0;
        wait_done(et, lat);
        p = (et != 0) ? prod1 : prod0;
        c = (et != 0) ? int'(cyc1) : int'(cyc0);
    endtask

    // done and busy must never be seen together.
    always @(negedge clk) begin
        checks++;
        if ((done0 && busy0) || (done1 && busy1)) begin
            errors++;
            $display("FAIL done_busy_overlap: dut0 %b%b dut1 %b%b required not both",
                     done0, busy0, done1, busy1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [2*W-1:0] p;
        int c, lat, seen;
        logic [W-1:0] a, b;
        logic s;
        int et;

        vecs[0] = '{16'hFFFD, 16'h0007, 1'b1, 0, 32'hFFFFFFEB, 9};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 9};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 32'h00000001, 9};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 0, 32'h40000000, 9};
        vecs[4] = '{16'h0000, 16'h1234, 1'b0, 0, 32'h00000000, 9};
        vecs[5] = '{16'h0123, 16'h0001, 1'b1, 1, 32'h00000123, 1};
        vecs[6] = '{16'h0123, 16'hFFFF, 1'b1, 1, 32'hFFFFFEDD, 1};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 0, 32'h3FFF0001, 9};
        vecs[8] = '{16'h8000, 16'h7FFF, 1'b1, 0, 32'hC0008000, 9};
        vecs[9] = '{16'hFFFF, 16'h0001, 1'b0, 1, 32'h0000FFFF, 1};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sm = 1'b0; md = '0; mr = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_product", 64'(prod0), 64'd0);
        chk("reset_cycles", 64'(cyc0), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].et, vecs[i].a, vecs[i].b, vecs[i].s, p, c, lat);
            chk($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].p));
            chk($sformatf("vec%0d_cycles", i), 64'(c), 64'(vecs[i].c));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].c));
        end

        for (int i = 0; i < 160; i++) begin
            et = i % 2;
            a  = W'($urandom);
            b  = W'($urandom);
            s  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) b = ~W'($urandom_range(0, 15));
            do_op(et, a, b, s, p, c, lat);
            chk($sformatf("rand%0d_product", i), 64'(p), 64'(ref_prod(a, b, s)));
            chk($sformatf("rand%0d_cycles", i), 64'(c), 64'(ref_cycles(b, s, et)));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_cycles(b, s, et)));
        end

        // Start pulsed mid-run with new operands must be ignored.
        @(negedge clk);
        md = 16'h1234; mr = 16'h5678; sm = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        md = 16'hFFFF; mr = 16'hFFFF; sm = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 4;
        wait_done(0, lat);
        chk("midrun_start_product", 64'(prod0), 64'(ref_prod(16'h1234, 16'h5678, 1'b0)));
        chk("midrun_start_latency", 64'(lat), 64'(NDIG));

        // Start held in the DONE cycle launches a back-to-back operation.
        @(negedge clk);
        md = 16'h00FF; mr = 16'h0F0F; sm = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 0;
        wait_done(0, lat);
        chk("b2b_first_product", 64'(prod0), 64'(ref_prod(16'h00FF, 16'h0F0F, 1'b0)));
        md = 16'hFFF0; mr = 16'h0010; sm = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("b2b_busy_after_accept", 64'(busy0), 64'd1);
        lat = 0;
        wait_done(0, lat);
        chk("b2b_second_product", 64'(prod0), 64'hFFFFFF00);
        chk("b2b_second_latency", 64'(lat), 64'(NDIG));

        // Reset at digit 4 aborts the run with no done.
        @(negedge clk);
        md = 16'h7777; mr = 16'h3333; sm = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before_reset", 64'(busy0), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_product", 64'(prod0), 64'd0);
        chk("abort_cycles", 64'(cyc0), 64'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0 || busy0) seen++;
        end
        chk("abort_no_done_later", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
